// File: rtl/ysyx_24120013_pkg.sv
// Shared widths and the write-back queue entry type for the WBU and its
// register file.
package ysyx_24120013_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NR_GPR     = 32;
  localparam int unsigned WB_DEPTH   = 2;

  typedef struct packed {
    logic                  wen;
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_24120013_regfile.sv
// Architectural GPR array: one write port, two combinational read ports,
// with x0 hardwired to zero on both the write and read sides.
module ysyx_24120013_regfile
  import ysyx_24120013_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata2_o
);

  logic [DATA_WIDTH-1:0] gpr_q [NR_GPR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_q <= '{default: '0};
    end else if (we_i && (waddr_i != '0)) begin
      gpr_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : gpr_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : gpr_q[raddr2_i];

endmodule

// File: rtl/ysyx_24120013_wbu.sv
// Write-back unit: in-order queue of EXU results retired one per cycle into
// the GPR array, with read ports that forward the youngest pending write.
module ysyx_24120013_wbu
  import ysyx_24120013_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic [REG_ADDR_W-1:0] in_waddr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic                  wb_stall,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  busy,
  output logic [31:0]           retire_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t             queue_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [31:0]           retire_q, retire_d;
  logic                  push, pop;
  wb_entry_t             head_entry;
  logic [PTR_W-1:0]      fwd_idx;
  logic [DATA_WIDTH-1:0] rf_rdata1, rf_rdata2;

  // in_ready looks only at registered occupancy, so wb_stall never reaches it combinationally
  assign in_ready   = rst && (count_q < DEPTH_C);
  assign push       = in_valid && in_ready;
  assign pop        = (count_q != '0) && !wb_stall;
  assign head_entry = queue_q[head_q];
  assign busy       = (count_q != '0);
  assign retire_cnt = retire_q;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    retire_d = retire_q;
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d   = head_q + PTR_W'(1);
      retire_d = retire_q + 32'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      retire_q <= '0;
      queue_q  <= '{default: '0};
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      retire_q <= retire_d;
      if (push) begin
        queue_q[tail_q] <= '{wen: in_wen, waddr: in_waddr, wdata: in_wdata};
      end
    end
  end

  ysyx_24120013_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst),
    .we_i     (pop && head_entry.wen),
    .waddr_i  (head_entry.waddr),
    .wdata_i  (head_entry.wdata),
    .raddr1_i (rs1_addr),
    .rdata1_o (rf_rdata1),
    .raddr2_i (rs2_addr),
    .rdata2_o (rf_rdata2)
  );

  // Walk oldest to youngest so the last match (youngest entry) wins
  always_comb begin
    rs1_data = rf_rdata1;
    rs2_data = rf_rdata2;
    fwd_idx  = head_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && queue_q[fwd_idx].wen) begin
        if (queue_q[fwd_idx].waddr == rs1_addr) rs1_data = queue_q[fwd_idx].wdata;
        if (queue_q[fwd_idx].waddr == rs2_addr) rs2_data = queue_q[fwd_idx].wdata;
      end
    end
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end

endmodule

// File: tb/tb_ysyx_24120013_wbu.sv
// Directed bench for the write-back unit: reset, single write, x0/wen=0,
// full+stall with forwarding, streaming, and reset mid-operation.
module tb_ysyx_24120013_wbu;
  import ysyx_24120013_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic        wb_stall;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic        busy;
  logic [31:0] retire_cnt;

  int assertCount = 0;
  int failCount   = 0;

  ysyx_24120013_wbu dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wen     (in_wen),
    .in_waddr   (in_waddr),
    .in_wdata   (in_wdata),
    .wb_stall   (wb_stall),
    .rs1_addr   (rs1_addr),
    .rs1_data   (rs1_data),
    .rs2_addr   (rs2_addr),
    .rs2_data   (rs2_data),
    .busy       (busy),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic wen,
                               input logic [4:0] waddr, input logic [31:0] wdata);
    in_valid = valid;
    in_wen   = wen;
    in_waddr = waddr;
    in_wdata = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    rst      = 1'b0;
    wb_stall = 1'b0;
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_retire", retire_cnt, 32'd0);
    checkOutput("rst_rs1_x5", rs1_data, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rel_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] single write");
    step();
    applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("sw_fwd_x5", rs1_data, 32'hDEAD_BEEF);
    checkOutput("sw_busy_q", 32'(busy), 32'd1);
    checkOutput("sw_retire_q", retire_cnt, 32'd0);
    step();
    checkOutput("sw_gpr_x5", rs1_data, 32'hDEAD_BEEF);
    checkOutput("sw_busy", 32'(busy), 32'd0);
    checkOutput("sw_retire", retire_cnt, 32'd1);

    $display("[TB] x0 and wen=0");
    rs1_addr = 5'd0;
    rs2_addr = 5'd7;
    applyStimulus(1'b1, 1'b1, 5'd0, 32'h1234);
    step();
    applyStimulus(1'b1, 1'b0, 5'd7, 32'h55);
    #1;
    checkOutput("x0_fwd", rs1_data, 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("wen0_no_fwd_x7", rs2_data, 32'd0);
    checkOutput("x0_retire_mid", retire_cnt, 32'd2);
    step();
    checkOutput("x0_rs1", rs1_data, 32'd0);
    checkOutput("wen0_rs2_x7", rs2_data, 32'd0);
    checkOutput("x0_retire", retire_cnt, 32'd3);
    rs1_addr = 5'd5;
    #1;
    checkOutput("x0_x5_kept", rs1_data, 32'hDEAD_BEEF);

    $display("[TB] full with stall");
    wb_stall = 1'b1;
    rs1_addr = 5'd3;
    rs2_addr = 5'd4;
    applyStimulus(1'b1, 1'b1, 5'd3, 32'd1);
    step();
    applyStimulus(1'b1, 1'b1, 5'd3, 32'd2);
    step();
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_busy", 32'(busy), 32'd1);
    checkOutput("full_youngest_x3", rs1_data, 32'd2);
    applyStimulus(1'b1, 1'b1, 5'd4, 32'h44);
    step();
    checkOutput("held_in_ready", 32'(in_ready), 32'd0);
    checkOutput("held_retire", retire_cnt, 32'd3);
    checkOutput("held_x3", rs1_data, 32'd2);
    checkOutput("held_x4", rs2_data, 32'd0);
    wb_stall = 1'b0;
    step();
    checkOutput("freed_in_ready", 32'(in_ready), 32'd1);
    checkOutput("freed_retire", retire_cnt, 32'd4);
    checkOutput("freed_x3_fwd", rs1_data, 32'd2);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("third_fwd_x4", rs2_data, 32'h44);
    checkOutput("third_retire", retire_cnt, 32'd5);
    step();
    checkOutput("drain_x3", rs1_data, 32'd2);
    checkOutput("drain_x4", rs2_data, 32'h44);
    checkOutput("drain_busy", 32'(busy), 32'd0);
    checkOutput("drain_retire", retire_cnt, 32'd6);

    $display("[TB] streaming");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(i), 32'(i * 16));
      step();
      checkOutput("stream_retire", retire_cnt, 32'(6 + i - 1));
      checkOutput("stream_ready", 32'(in_ready), 32'd1);
      checkOutput("stream_busy", 32'(busy), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("stream_final_retire", retire_cnt, 32'd14);
    checkOutput("stream_final_busy", 32'(busy), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      rs1_addr = 5'(i);
      #1;
      checkOutput("stream_gpr", rs1_data, 32'(i * 16));
    end

    $display("[TB] reset mid-operation");
    wb_stall = 1'b1;
    rs1_addr = 5'd9;
    rs2_addr = 5'd1;
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h91);
    step();
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h92);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    checkOutput("mid_fwd_x9", rs1_data, 32'h92);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_retire", retire_cnt, 32'd0);
    checkOutput("mid_rst_x9", rs1_data, 32'd0);
    checkOutput("mid_rst_x1", rs2_data, 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    wb_stall = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    checkOutput("post_rst_x9", rs1_data, 32'd0);
    checkOutput("post_rst_retire", retire_cnt, 32'd0);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
